mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- MEM-stage responder for CPU load/store requests in the 5-stage RISC-V pipeline.
- Converts one pipeline-side access into a variable-latency req/ack transaction on the data-memory bus.
- Performs byte/halfword lane steering, store strobes and load sign/zero extension.
- Raises stall_mem toward the hazard unit for as long as the access is outstanding. The hazard unit consumes stall requests; this block is the producer at the other end of that interface.

Parameters:
- TIMEOUT, 64: cycles to wait for mem_ack before abandoning the access and flagging bus_err.
- CNT_W, 7: width of the timeout counter. Must hold TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge
- rstn  in  1  reset, asynchronous, active-low
- req_valid  in  1  MEM stage holds a load/store; held stable by the pipeline while stall_mem=1
- req_we  in  1  1 = store, 0 = load
- funct3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU; other codes are illegal
- addr  in  32  byte address
- wdata  in  32  store data, right-aligned
- rdata  out  32  extended load result, valid while done=1
- done  out  1  one-cycle pulse: access complete, pipeline may advance
- stall_mem  out  1  stall request to hazard unit
- misalign  out  1  with done: access was misaligned or funct3 was illegal; no bus access was made
- bus_err  out  1  with done: the access timed out
- mem_req  out  1  bus request, registered
- mem_we  out  1  bus write
- mem_addr  out  30  word address, addr[31:2]
- mem_wdata  out  32  lane-shifted store data
- mem_wstrb  out  4  byte strobes; 0000 on reads
- mem_rdata  in  32  bus read word
- mem_ack  in  1  single-cycle completion from memory

Behaviour:
- FSM states: IDLE, BUSY, DONE.
- Reset (rstn low, any time, including mid-transaction):
  - State returns to IDLE; counter cleared.
  - All outputs are 0.
  - A pending bus access is abandoned; the memory must also be reset.
- IDLE:
  - stall_mem = req_valid (combinational), so the hazard unit stalls in the same cycle the request appears.
  - If req_valid and the access is aligned with a legal funct3:
    - Next cycle: state BUSY, mem_req=1.
    - mem_addr, mem_we, mem_wdata and mem_wstrb are registered from the inputs.
    - Counter cleared.
  - If req_valid and the access is misaligned or funct3 is illegal: next cycle state DONE with misalign=1, rdata=0; no mem_req.
  - Alignment rule: H/HU need addr[0]=0; W needs addr[1:0]=00.
- BUSY:
  - stall_mem=1. mem_req and the bus fields are held until mem_ack.
  - Counter increments each cycle.
  - On mem_ack:
    - mem_req drops on the next edge.
    - rdata is registered from mem_rdata, shifted right by 8*addr[1:0], then sign-extended (B, H) or zero-extended (BU, HU, W passes through).
    - Next state DONE.
  - If the counter reaches TIMEOUT-1 without ack: mem_req drops, next state DONE with bus_err=1, rdata=0.
  - mem_ack and timeout in the same cycle: ack wins, no error.
- DONE:
  - done=1, stall_mem=0 for exactly one cycle.
  - rdata, misalign and bus_err are held valid.
  - Next state IDLE; done, misalign and bus_err return to 0.
  - A new request is not sampled in DONE. The next instruction arrives in the following cycle and is handled in IDLE.
- Store lanes:
  - B: wstrb = 0001 << addr[1:0], data replicated to all four bytes.
  - H: wstrb = 0011 << addr[1:0], halfword replicated to both halves.
  - W: wstrb = 1111.
- mem_ack outside BUSY is ignored.
- req_valid dropping while BUSY does not cancel the access; the store or load completes.
- Minimum latency:
  - Request seen in cycle 0, mem_req from cycle 1.
  - Ack in cycle 1 gives done in cycle 2.
  - stall_mem is high in cycles 0–1.

Decomposition:
- Shared package:
  - funct3 load/store encodings
  - FSM state encoding
  - stall/flush interface bit definitions common with the hazard unit
- One sub-module, mem_lane_align: purely combinational store strobe/data shifting and load extraction/extension. Keeps the FSM file small and allows exhaustive lane testing.

Test Plan:
- LW: addr 0x100, mem_rdata 0xDEADBEEF, ack 3 cycles after mem_req → mem_addr=0x40, stall_mem high 4 cycles, then done with rdata=0xDEADBEEF.
- LB/LBU: addr 0x103, mem_rdata 0x80FF_1234 → LB gives rdata=0xFFFFFF80, LBU gives 0x00000080.
- SH: addr 0x202, wdata 0x0000ABCD → mem_wstrb=1100, mem_wdata=0xABCDABCD, mem_we=1.
- Misaligned LW: addr 0x101 → no mem_req, done+misalign next cycle, rdata=0. Illegal funct3=011 gives the same result.
- Timeout: never ack, TIMEOUT=8 → mem_req drops, done+bus_err=1, rdata=0. Ack arriving on the last counted cycle gives no error.
- Reset mid-BUSY: drop rstn while mem_req=1 → all outputs 0 immediately. After release, a fresh LW completes normally.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the MEM-stage access unit: funct3 encodings, FSM states
// and the stall/flush request bundle exchanged with the hazard unit.
package mem_access_unit_pkg;

    localparam logic [2:0] Funct3Byte   = 3'b000;
    localparam logic [2:0] Funct3Half   = 3'b001;
    localparam logic [2:0] Funct3Word   = 3'b010;
    localparam logic [2:0] Funct3ByteU  = 3'b100;
    localparam logic [2:0] Funct3HalfU  = 3'b101;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StDone = 2'd2
    } mau_state_e;

    // Request bundle as seen by the hazard unit; this block only drives the stall bit.
    typedef struct packed {
        logic flush;
        logic stall;
    } hz_ctrl_t;

    // Legal funct3 with a naturally aligned address.
    function automatic logic access_ok(input logic [2:0] f3, input logic [1:0] off);
        unique case (f3)
            Funct3Byte, Funct3ByteU: access_ok = 1'b1;
            Funct3Half, Funct3HalfU: access_ok = ~off[0];
            Funct3Word:              access_ok = (off == 2'b00);
            default:                 access_ok = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering: store strobes/data replication and load
// extraction with sign or zero extension.
module mem_lane_align
    import mem_access_unit_pkg::*;
(
    input  logic [2:0]  st_funct3_i,
    input  logic [1:0]  st_off_i,
    input  logic [31:0] st_wdata_i,
    output logic [3:0]  st_wstrb_o,
    output logic [31:0] st_wdata_o,
    input  logic [2:0]  ld_funct3_i,
    input  logic [1:0]  ld_off_i,
    input  logic [31:0] ld_word_i,
    output logic [31:0] ld_rdata_o
);

    logic [31:0] ld_shifted;

    always_comb begin
        st_wstrb_o = 4'b0000;
        st_wdata_o = '0;
        unique case (st_funct3_i)
            Funct3Byte, Funct3ByteU: begin
                st_wstrb_o = 4'b0001 << st_off_i;
                st_wdata_o = {4{st_wdata_i[7:0]}};
            end
            Funct3Half, Funct3HalfU: begin
                st_wstrb_o = 4'b0011 << st_off_i;
                st_wdata_o = {2{st_wdata_i[15:0]}};
            end
            Funct3Word: begin
                st_wstrb_o = 4'b1111;
                st_wdata_o = st_wdata_i;
            end
            default: ;
        endcase
    end

    always_comb begin
        ld_shifted = ld_word_i >> {ld_off_i, 3'b000};
        ld_rdata_o = '0;
        unique case (ld_funct3_i)
            Funct3Byte:  ld_rdata_o = {{24{ld_shifted[7]}}, ld_shifted[7:0]};
            Funct3ByteU: ld_rdata_o = {24'h0, ld_shifted[7:0]};
            Funct3Half:  ld_rdata_o = {{16{ld_shifted[15]}}, ld_shifted[15:0]};
            Funct3HalfU: ld_rdata_o = {16'h0, ld_shifted[15:0]};
            Funct3Word:  ld_rdata_o = ld_word_i;
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store responder: turns one pipeline access into a req/ack bus
// transaction with timeout, stalling the pipeline until it completes.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned CNT_W   = 7
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        done,
    output logic        stall_mem,
    output logic        misalign,
    output logic        bus_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [29:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    mau_state_e  state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [29:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_wstrb_q, mem_wstrb_d;
    logic [2:0]  f3_q, f3_d;
    logic [1:0]  off_q, off_d;
    logic [31:0] rdata_q, rdata_d;
    logic        misalign_q, misalign_d;
    logic        bus_err_q, bus_err_d;

    logic [3:0]  st_wstrb;
    logic [31:0] st_wdata;
    logic [31:0] ld_rdata;
    hz_ctrl_t    hz_req;

    mem_lane_align u_lane (
        .st_funct3_i (funct3),
        .st_off_i    (addr[1:0]),
        .st_wdata_i  (wdata),
        .st_wstrb_o  (st_wstrb),
        .st_wdata_o  (st_wdata),
        .ld_funct3_i (f3_q),
        .ld_off_i    (off_q),
        .ld_word_i   (mem_rdata),
        .ld_rdata_o  (ld_rdata)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;
        f3_d        = f3_q;
        off_d       = off_q;
        rdata_d     = rdata_q;
        misalign_d  = misalign_q;
        bus_err_d   = bus_err_q;
        hz_req      = '0;

        unique case (state_q)
            StIdle: begin
                hz_req.stall = req_valid;
                misalign_d   = 1'b0;
                bus_err_d    = 1'b0;
                if (req_valid) begin
                    if (access_ok(funct3, addr[1:0])) begin
                        state_d     = StBusy;
                        cnt_d       = '0;
                        mem_req_d   = 1'b1;
                        mem_we_d    = req_we;
                        mem_addr_d  = addr[31:2];
                        mem_wdata_d = req_we ? st_wdata : '0;
                        mem_wstrb_d = req_we ? st_wstrb : 4'b0000;
                        f3_d        = funct3;
                        off_d       = addr[1:0];
                    end else begin
                        state_d    = StDone;
                        misalign_d = 1'b1;
                        rdata_d    = '0;
                    end
                end
            end
            StBusy: begin
                hz_req.stall = 1'b1;
                cnt_d        = cnt_q + CNT_W'(1);
                // Ack is checked first so a last-cycle ack beats the timeout.
                if (mem_ack) begin
                    state_d   = StDone;
                    mem_req_d = 1'b0;
                    rdata_d   = ld_rdata;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d   = StDone;
                    mem_req_d = 1'b0;
                    bus_err_d = 1'b1;
                    rdata_d   = '0;
                end
            end
            StDone: begin
                state_d    = StIdle;
                misalign_d = 1'b0;
                bus_err_d  = 1'b0;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= 4'b0000;
            f3_q        <= 3'b000;
            off_q       <= 2'b00;
            rdata_q     <= '0;
            misalign_q  <= 1'b0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
            f3_q        <= f3_d;
            off_q       <= off_d;
            rdata_q     <= rdata_d;
            misalign_q  <= misalign_d;
            bus_err_q   <= bus_err_d;
        end
    end

    // Gated by rstn so the combinational stall is also 0 while held in reset.
    assign stall_mem = hz_req.stall & rstn;
    assign done      = (state_q == StDone);
    assign rdata     = rdata_q;
    assign misalign  = misalign_q;
    assign bus_err   = bus_err_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wstrb = mem_wstrb_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized and directed bench for mem_access_unit against a behavioural model.
module tb_mem_access_unit;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        done, stall_mem, misalign, bus_err;
    logic        mem_req, mem_we;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;

    int total = 0;
    int bad = 0;

    // Observations of the last access.
    int          obs_stall, obs_req, obs_done_c;
    logic [31:0] obs_rdata, obs_wdata;
    logic        obs_mis, obs_err, obs_we, obs_hold_ok, obs_stall_done;
    logic [29:0] obs_addr;
    logic [3:0]  obs_wstrb;

    mem_access_unit #(.TIMEOUT(TO), .CNT_W(7)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .req_valid (req_valid),
        .req_we    (req_we),
        .funct3    (funct3),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .done      (done),
        .stall_mem (stall_mem),
        .misalign  (misalign),
        .bus_err   (bus_err),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    function automatic bit m_legal(input logic [2:0] f3, input logic [31:0] a);
        int off = int'(a % 4);
        if (f3 == 3'd0 || f3 == 3'd4) return 1;
        if (f3 == 3'd1 || f3 == 3'd5) return (off % 2) == 0;
        if (f3 == 3'd2) return off == 0;
        return 0;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] word);
        logic [31:0] v = word >> (8 * (a % 4));
        logic [31:0] b = v % 256;
        logic [31:0] h = v % 65536;
        case (f3)
            3'd0:    return (b >= 128) ? b + 32'hFFFFFF00 : b;
            3'd4:    return b;
            3'd1:    return (h >= 32768) ? h + 32'hFFFF0000 : h;
            3'd5:    return h;
            default: return word;
        endcase
    endfunction

    function automatic logic [3:0] m_strb(input logic [2:0] f3, input logic [31:0] a);
        int off = int'(a % 4);
        if (f3 == 3'd0) return 4'(1 << off);
        if (f3 == 3'd1) return 4'(3 << off);
        return 4'hF;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
        if (f3 == 3'd0) return (wd % 256) * 32'h01010101;
        if (f3 == 3'd1) return (wd % 65536) * 32'h00010001;
        return wd;
    endfunction

    // ---------------- driver (no checking) ----------------
    // ack_at: BUSY cycle (1-based) carrying mem_ack; 0 = never. drop_at: cycle to release req_valid.
    task automatic drive_access(input logic we, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] wd, input logic [31:0] rw,
                                input int ack_at, input int drop_at);
        @(negedge clk);
        req_valid = 1'b1; req_we = we; funct3 = f3; addr = a; wdata = wd; mem_ack = 1'b0;
        obs_stall = 0; obs_req = 0; obs_done_c = -1; obs_hold_ok = 1'b1;
        obs_rdata = 'x; obs_mis = 1'bx; obs_err = 1'bx; obs_stall_done = 1'bx;
        obs_addr = 'x; obs_we = 1'bx; obs_wdata = 'x; obs_wstrb = 'x;
        for (int c = 0; c < 4 * TO; c++) begin
            if (c == drop_at) req_valid = 1'b0;
            #1;
            if (done) begin
                obs_done_c = c; obs_rdata = rdata; obs_mis = misalign; obs_err = bus_err;
                obs_stall_done = stall_mem;
                break;
            end
            if (stall_mem) obs_stall++;
            if (mem_req) begin
                obs_req++;
                if (obs_req == 1) begin
                    obs_addr = mem_addr; obs_we = mem_we; obs_wdata = mem_wdata;
                    obs_wstrb = mem_wstrb;
                end else if (obs_addr !== mem_addr || obs_we !== mem_we ||
                             obs_wdata !== mem_wdata || obs_wstrb !== mem_wstrb) begin
                    obs_hold_ok = 1'b0;
                end
            end
            mem_ack = mem_req && (obs_req == ack_at);
            mem_rdata = mem_ack ? rw : $urandom();
            @(negedge clk);
        end
        req_valid = 1'b0;
        mem_ack = 1'b0;
    endtask

    // ---------------- feature tasks ----------------
    task automatic test_reset();
        rstn = 1'b0; req_valid = 1'b1; funct3 = 3'd2; addr = 32'h100;
        #1;
        total++;
        if ({rdata, done, stall_mem, misalign, bus_err, mem_req, mem_we} !== 38'd0) begin
            bad++; $display("FAIL reset_ctrl: got %h want 0",
                {rdata, done, stall_mem, misalign, bus_err, mem_req, mem_we});
        end
        total++;
        if ({mem_addr, mem_wdata, mem_wstrb} !== 66'd0) begin
            bad++; $display("FAIL reset_bus: got %h want 0", {mem_addr, mem_wdata, mem_wstrb});
        end
        req_valid = 1'b0;
        @(negedge clk); rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_lw();
        drive_access(1'b0, 3'd2, 32'h100, 32'h0, 32'hDEADBEEF, 3, -1);
        total++; if (obs_addr !== 30'h40) begin bad++;
            $display("FAIL lw_addr: got %h want 40", obs_addr); end
        total++; if (obs_stall != 4) begin bad++;
            $display("FAIL lw_stall: got %0d want 4", obs_stall); end
        total++; if (obs_done_c != 4) begin bad++;
            $display("FAIL lw_latency: got %0d want 4", obs_done_c); end
        total++; if (obs_rdata !== 32'hDEADBEEF) begin bad++;
            $display("FAIL lw_rdata: got %h want deadbeef", obs_rdata); end
        total++; if ({obs_mis, obs_err, obs_we, obs_wstrb, obs_stall_done} !== 8'd0) begin bad++;
            $display("FAIL lw_flags: got %b want 0",
                {obs_mis, obs_err, obs_we, obs_wstrb, obs_stall_done}); end
    endtask

    task automatic test_lb_lbu();
        drive_access(1'b0, 3'd0, 32'h103, 32'h0, 32'h80FF1234, 1, -1);
        total++; if (obs_rdata !== 32'hFFFFFF80) begin bad++;
            $display("FAIL lb_rdata: got %h want ffffff80", obs_rdata); end
        total++; if (obs_done_c != 2 || obs_stall != 2) begin bad++;
            $display("FAIL lb_min_latency: got done@%0d stall=%0d want 2/2", obs_done_c, obs_stall); end
        drive_access(1'b0, 3'd4, 32'h103, 32'h0, 32'h80FF1234, 2, -1);
        total++; if (obs_rdata !== 32'h00000080) begin bad++;
            $display("FAIL lbu_rdata: got %h want 00000080", obs_rdata); end
    endtask

    task automatic test_sh();
        drive_access(1'b1, 3'd1, 32'h202, 32'h0000ABCD, 32'h0, 2, -1);
        total++; if (obs_wstrb !== 4'b1100) begin bad++;
            $display("FAIL sh_wstrb: got %b want 1100", obs_wstrb); end
        total++; if (obs_wdata !== 32'hABCDABCD) begin bad++;
            $display("FAIL sh_wdata: got %h want abcdabcd", obs_wdata); end
        total++; if (obs_we !== 1'b1 || obs_addr !== 30'h80 || !obs_hold_ok) begin bad++;
            $display("FAIL sh_bus: got we=%b addr=%h hold=%b want 1/80/1",
                obs_we, obs_addr, obs_hold_ok); end
    endtask

    task automatic test_misalign();
        drive_access(1'b0, 3'd2, 32'h101, 32'h0, 32'h12345678, 1, -1);
        total++; if (obs_req != 0 || obs_done_c != 1 || obs_mis !== 1'b1 || obs_rdata !== 32'h0)
        begin bad++; $display("FAIL misalign_lw: got req=%0d done@%0d mis=%b rdata=%h want 0/1/1/0",
            obs_req, obs_done_c, obs_mis, obs_rdata); end
        drive_access(1'b0, 3'd3, 32'h100, 32'h0, 32'h12345678, 1, -1);
        total++; if (obs_req != 0 || obs_done_c != 1 || obs_mis !== 1'b1 || obs_err !== 1'b0)
        begin bad++; $display("FAIL illegal_f3: got req=%0d done@%0d mis=%b err=%b want 0/1/1/0",
            obs_req, obs_done_c, obs_mis, obs_err); end
    endtask

    task automatic test_timeout();
        drive_access(1'b0, 3'd2, 32'h400, 32'h0, 32'h55AA55AA, 0, -1);
        total++; if (obs_req != TO || obs_done_c != TO + 1) begin bad++;
            $display("FAIL timeout_len: got req=%0d done@%0d want %0d/%0d",
                obs_req, obs_done_c, TO, TO + 1); end
        total++; if (obs_err !== 1'b1 || obs_rdata !== 32'h0 || obs_mis !== 1'b0) begin bad++;
            $display("FAIL timeout_err: got err=%b rdata=%h mis=%b want 1/0/0",
                obs_err, obs_rdata, obs_mis); end
        drive_access(1'b0, 3'd2, 32'h400, 32'h0, 32'h55AA55AA, TO, -1);
        total++; if (obs_err !== 1'b0 || obs_rdata !== 32'h55AA55AA || obs_done_c != TO + 1)
        begin bad++; $display("FAIL last_cycle_ack: got err=%b rdata=%h done@%0d want 0/55aa55aa/%0d",
            obs_err, obs_rdata, obs_done_c, TO + 1); end
    endtask

    task automatic test_drop_valid();
        drive_access(1'b1, 3'd2, 32'h800, 32'hCAFEF00D, 32'h0, 4, 2);
        total++; if (obs_done_c != 5 || obs_err !== 1'b0 || obs_wdata !== 32'hCAFEF00D) begin bad++;
            $display("FAIL drop_valid: got done@%0d err=%b wdata=%h want 5/0/cafef00d",
                obs_done_c, obs_err, obs_wdata); end
    endtask

    task automatic test_ack_idle();
        logic seen;
        seen = 1'b0;
        @(negedge clk); mem_ack = 1'b1; mem_rdata = 32'hFFFFFFFF;
        @(negedge clk); mem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1; if (done || mem_req || stall_mem) seen = 1'b1;
            @(negedge clk);
        end
        total++; if (seen !== 1'b0) begin bad++;
            $display("FAIL ack_in_idle: got activity=%b want 0", seen); end
    endtask

    task automatic test_reset_mid_busy();
        int waited;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; funct3 = 3'd2; addr = 32'h300; wdata = $urandom();
        waited = 0;
        #1;
        while (!mem_req && waited < 8) begin @(negedge clk); #1; waited++; end
        @(negedge clk);
        total++; if (mem_req !== 1'b1) begin bad++;
            $display("FAIL rst_mid_setup: got mem_req=%b want 1", mem_req); end
        #1 rstn = 1'b0;
        #1;
        total++;
        if ({rdata, done, stall_mem, misalign, bus_err, mem_req, mem_we,
             mem_addr, mem_wdata, mem_wstrb} !== 104'd0) begin bad++;
            $display("FAIL rst_mid_outputs: got %h want 0", {rdata, done, stall_mem, misalign,
                bus_err, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb}); end
        req_valid = 1'b0;
        @(negedge clk); rstn = 1'b1;
        drive_access(1'b0, 3'd2, 32'h10, 32'h0, 32'h0BADF00D, 2, -1);
        total++; if (obs_rdata !== 32'h0BADF00D || obs_done_c != 3 || obs_addr !== 30'h4) begin bad++;
            $display("FAIL rst_mid_after: got rdata=%h done@%0d addr=%h want 0badf00d/3/4",
                obs_rdata, obs_done_c, obs_addr); end
    endtask

    task automatic test_random();
        logic [2:0]  f3tab [8];
        logic [2:0]  f3;
        logic [31:0] a, wd, rw;
        logic        we;
        int          ack_at, exp_c, exp_req;
        bit          legal, acked;
        f3tab = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};
        for (int it = 0; it < 60; it++) begin
            we = 1'($urandom_range(0, 1));
            f3 = we ? f3tab[$urandom_range(0, 2)] : f3tab[$urandom_range(0, 7)];
            if (we && $urandom_range(0, 9) == 0) f3 = 3'd3;
            a = $urandom(); wd = $urandom(); rw = $urandom();
            ack_at = $urandom_range(0, TO + 1);
            if ($urandom_range(0, 2) != 0) a = a & ~32'h3 | (a & 32'h3 & {30'h0, 1'b0, f3 == 3'd0});
            legal = m_legal(f3, a);
            acked = (ack_at >= 1 && ack_at <= TO);
            exp_c = !legal ? 1 : (acked ? ack_at + 1 : TO + 1);
            exp_req = !legal ? 0 : (acked ? ack_at : TO);
            drive_access(we, f3, a, wd, rw, ack_at, -1);
            total++; if (obs_done_c != exp_c || obs_stall != exp_c || obs_req != exp_req) begin bad++;
                $display("FAIL rnd_timing[%0d]: got done@%0d stall=%0d req=%0d want %0d/%0d/%0d",
                    it, obs_done_c, obs_stall, obs_req, exp_c, exp_c, exp_req); end
            total++; if (obs_mis !== !legal || obs_err !== (legal && !acked)) begin bad++;
                $display("FAIL rnd_flags[%0d]: got mis=%b err=%b want %b/%b",
                    it, obs_mis, obs_err, !legal, legal && !acked); end
            if (!legal || !acked) begin
                total++; if (obs_rdata !== 32'h0) begin bad++;
                    $display("FAIL rnd_rdata_zero[%0d]: got %h want 0", it, obs_rdata); end
            end else if (!we) begin
                total++; if (obs_rdata !== m_load(f3, a, rw)) begin bad++;
                    $display("FAIL rnd_load[%0d]: f3=%0d a=%h got %h want %h",
                        it, f3, a, obs_rdata, m_load(f3, a, rw)); end
            end
            if (legal) begin
                total++;
                if (obs_addr !== a[31:2] || obs_we !== we || !obs_hold_ok ||
                    obs_wstrb !== (we ? m_strb(f3, a) : 4'h0)) begin bad++;
                    $display("FAIL rnd_bus[%0d]: got addr=%h we=%b strb=%b hold=%b want %h/%b/%b/1",
                        it, obs_addr, obs_we, obs_wstrb, obs_hold_ok, a[31:2], we,
                        we ? m_strb(f3, a) : 4'h0); end
                if (we) begin
                    total++; if (obs_wdata !== m_wdata(f3, wd)) begin bad++;
                        $display("FAIL rnd_wdata[%0d]: got %h want %h",
                            it, obs_wdata, m_wdata(f3, wd)); end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_lb_lbu();
        test_sh();
        test_misalign();
        test_timeout();
        test_drop_valid();
        test_ack_idle();
        test_reset_mid_busy();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
